// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - parametrised APB4 register bank slave with wait states, strobes and write masks
//
// Ports:
//   clk      : clock, all logic on the rising edge
//   rst      : asynchronous active-low reset
//   psel     : slave select
//   penable  : access phase
//   pwrite   : 1 = write, 0 = read
//   paddr    : byte address
//   pwdata   : write data
//   pstrb    : byte write strobes
//   prdata   : read data, non-zero only on a completing read hit
//   pready   : transfer complete
//   pslverr  : transfer error (unmapped or misaligned), qualified by pready
//   reg_q    : flat export of all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]

module apb_regfile_slave #(
    parameter int                             DATA_WIDTH  = 32,
    parameter int                             ADDR_WIDTH  = 32,
    parameter int                             NUM_REGS    = 4,
    parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR   = 'h10,
    parameter int                             WAIT_CYCLES = 0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] WMASK       = '1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int                    BYTES      = DATA_WIDTH / 8;
    localparam int                    SHIFT      = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [3:0]            WAIT_LAST  = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [3:0]      wcnt;
    logic [3:0]      wcnt_n;
    logic            done;

    // Address decode
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] word;
    logic                  hit;

    assign off  = paddr - BASE_ADDR;
    assign word = off >> SHIFT;
    assign hit  = (paddr >= BASE_ADDR) && ((off & ALIGN_MASK) == '0) &&
                  (word < ADDR_WIDTH'(NUM_REGS));

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    // FSM next state; done marks the completing access cycle
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        done    = 1'b0;
        case (state)
            IDLE: begin
                // penable without a preceding setup phase is ignored
                if (psel && !penable) begin
                    state_n = ACCESS;
                    wcnt_n  = '0;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_n = IDLE;
                end else if (!penable) begin
                    // a fresh setup phase restarts the wait count
                    wcnt_n = '0;
                end else if (wcnt == WAIT_LAST) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else begin
                    wcnt_n = wcnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    logic wr_commit;
    logic rd_hit;

    assign wr_commit = done && pwrite && hit;
    assign rd_hit    = done && !pwrite && hit;

    assign pready  = done;
    assign pslverr = done && !hit;

    // Byte strobes expanded to a per-bit enable
    logic [DATA_WIDTH-1:0] byte_en;

    always_comb begin
        byte_en = '0;
        for (int b = 0; b < BYTES; b++) begin
            byte_en[b*8 +: 8] = {8{pstrb[b]}};
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] q;
        logic [DATA_WIDTH-1:0] bit_en;

        assign bit_en = byte_en & WMASK[i*DATA_WIDTH +: DATA_WIDTH];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q <= '0;
            end else if (wr_commit && (word == ADDR_WIDTH'(i))) begin
                q <= (q & ~bit_en) | (pwdata & bit_en);
            end
        end

        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = q;
    end

    // Read mux; zero unless a read hit is completing
    always_comb begin
        prdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_hit && (word == ADDR_WIDTH'(i))) begin
                prdata = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - self-checking bench for apb_regfile_slave over three parameter sets
//
// Instance 0: WAIT_CYCLES=0, all bits writable
// Instance 1: WAIT_CYCLES=2, reg1 write mask 0x0000000F
// Instance 2: WAIT_CYCLES=3, all bits writable

module tb_apb_regfile_slave;

    logic         clk = 1'b0;
    logic         rst_a     [3];
    logic         psel_a    [3];
    logic         penable_a [3];
    logic         pwrite_a  [3];
    logic [31:0]  paddr_a   [3];
    logic [31:0]  pwdata_a  [3];
    logic [3:0]   pstrb_a   [3];
    logic [31:0]  prdata_a  [3];
    logic         pready_a  [3];
    logic         pslverr_a [3];
    logic [127:0] regq_a    [3];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    apb_regfile_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h10),
        .WAIT_CYCLES(0), .WMASK({128{1'b1}})
    ) dut0 (
        .clk(clk), .rst(rst_a[0]), .psel(psel_a[0]), .penable(penable_a[0]),
        .pwrite(pwrite_a[0]), .paddr(paddr_a[0]), .pwdata(pwdata_a[0]),
        .pstrb(pstrb_a[0]), .prdata(prdata_a[0]), .pready(pready_a[0]),
        .pslverr(pslverr_a[0]), .reg_q(regq_a[0])
    );

    apb_regfile_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h10),
        .WAIT_CYCLES(2), .WMASK(128'hFFFFFFFF_FFFFFFFF_0000000F_FFFFFFFF)
    ) dut1 (
        .clk(clk), .rst(rst_a[1]), .psel(psel_a[1]), .penable(penable_a[1]),
        .pwrite(pwrite_a[1]), .paddr(paddr_a[1]), .pwdata(pwdata_a[1]),
        .pstrb(pstrb_a[1]), .prdata(prdata_a[1]), .pready(pready_a[1]),
        .pslverr(pslverr_a[1]), .reg_q(regq_a[1])
    );

    apb_regfile_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h10),
        .WAIT_CYCLES(3), .WMASK({128{1'b1}})
    ) dut2 (
        .clk(clk), .rst(rst_a[2]), .psel(psel_a[2]), .penable(penable_a[2]),
        .pwrite(pwrite_a[2]), .paddr(paddr_a[2]), .pwdata(pwdata_a[2]),
        .pstrb(pstrb_a[2]), .prdata(prdata_a[2]), .pready(pready_a[2]),
        .pslverr(pslverr_a[2]), .reg_q(regq_a[2])
    );

    typedef struct {
        int          d;
        bit          w;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    localparam int NV = 21;
    vec_t tbl[NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle(input int d);
        psel_a[d]    = 1'b0;
        penable_a[d] = 1'b0;
        pwrite_a[d]  = 1'b0;
        paddr_a[d]   = '0;
        pwdata_a[d]  = '0;
        pstrb_a[d]   = '0;
    endtask

    // One full APB transfer; expectation is queued at the setup phase and
    // popped when pready is seen
    task automatic xfer(input string name, input int d, input bit w, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [31:0] rdata, input logic err, input int cyc);
        int   n;
        logic got;
        exp_t e;
        @(posedge clk); #1;
        psel_a[d]    = 1'b1;
        penable_a[d] = 1'b0;
        pwrite_a[d]  = w;
        paddr_a[d]   = addr;
        pwdata_a[d]  = data;
        pstrb_a[d]   = strb;
        sb.push_back('{rdata, err, cyc});
        @(posedge clk); #1;
        penable_a[d] = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (pready_a[d]) begin
                got = 1'b1;
                e = sb.pop_front();
                check({name, " prdata"}, 128'(prdata_a[d]), 128'(e.rdata));
                check({name, " pslverr"}, 128'(pslverr_a[d]), 128'(e.err));
                check({name, " cycles"}, 128'(n + 1), 128'(e.cyc));
            end
        end
        check({name, " pready seen"}, 128'(got), 128'(1'b1));
        if (!got) void'(sb.pop_front());
        @(posedge clk); #1;
        bus_idle(d);
    endtask

    initial begin
        tbl[0]  = '{0, 1, 32'h14, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2};
        tbl[1]  = '{0, 0, 32'h14, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2};
        tbl[2]  = '{0, 1, 32'h18, 32'h11223344, 4'hF, 32'h0,        1'b0, 2};
        tbl[3]  = '{0, 1, 32'h18, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 2};
        tbl[4]  = '{0, 0, 32'h18, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 2};
        tbl[5]  = '{0, 1, 32'h18, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 2};
        tbl[6]  = '{0, 0, 32'h18, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 2};
        tbl[7]  = '{0, 1, 32'h20, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 2};
        tbl[8]  = '{0, 1, 32'h12, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 2};
        tbl[9]  = '{0, 1, 32'h0C, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 2};
        tbl[10] = '{0, 0, 32'h20, 32'h0,        4'h0, 32'h0,        1'b1, 2};
        tbl[11] = '{0, 0, 32'h12, 32'h0,        4'h0, 32'h0,        1'b1, 2};
        tbl[12] = '{0, 0, 32'h0C, 32'h0,        4'h0, 32'h0,        1'b1, 2};
        tbl[13] = '{0, 0, 32'h10, 32'h0,        4'h0, 32'h0,        1'b0, 2};
        tbl[14] = '{1, 0, 32'h10, 32'h0,        4'h0, 32'h0,        1'b0, 4};
        tbl[15] = '{1, 1, 32'h14, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, 4};
        tbl[16] = '{1, 0, 32'h14, 32'h0,        4'h0, 32'h0000000F, 1'b0, 4};
        tbl[17] = '{1, 1, 32'h10, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, 4};
        tbl[18] = '{1, 0, 32'h10, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0, 4};
        tbl[19] = '{2, 1, 32'h10, 32'h12345678, 4'hF, 32'h0,        1'b0, 5};
        tbl[20] = '{2, 0, 32'h10, 32'h0,        4'h0, 32'h12345678, 1'b0, 5};

        for (int d = 0; d < 3; d++) begin
            rst_a[d] = 1'b0;
            bus_idle(d);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset reg_q %0d", d), regq_a[d], 128'h0);
            check($sformatf("reset pready %0d", d), 128'(pready_a[d]), 128'h0);
            check($sformatf("reset pslverr %0d", d), 128'(pslverr_a[d]), 128'h0);
            check($sformatf("reset prdata %0d", d), 128'(prdata_a[d]), 128'h0);
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) rst_a[d] = 1'b1;

        for (int v = 0; v < NV; v++) begin
            xfer($sformatf("vec%0d", v), tbl[v].d, tbl[v].w, tbl[v].addr, tbl[v].data,
                 tbl[v].strb, tbl[v].rdata, tbl[v].err, tbl[v].cyc);
        end
        check("dut0 reg_q", regq_a[0], {32'h0, 32'h11BB33DD, 32'hDEADBEEF, 32'h0});
        check("dut1 reg_q", regq_a[1], {32'h0, 32'h0, 32'h0000000F, 32'hFFFFFFFF});

        // penable asserted straight from IDLE is not a transfer
        @(posedge clk); #1;
        psel_a[0] = 1'b1; penable_a[0] = 1'b1; pwrite_a[0] = 1'b1;
        paddr_a[0] = 32'h1C; pwdata_a[0] = 32'hFFFFFFFF; pstrb_a[0] = 4'hF;
        @(negedge clk);
        check("idle penable pready c1", 128'(pready_a[0]), 128'h0);
        @(negedge clk);
        check("idle penable pready c2", 128'(pready_a[0]), 128'h0);
        @(posedge clk); #1;
        bus_idle(0);
        @(negedge clk);
        check("idle penable no write", regq_a[0][127:96], 128'h0);

        // abort: psel dropped in the second access cycle of a write
        begin
            logic seen;
            seen = 1'b0;
            @(posedge clk); #1;
            psel_a[2] = 1'b1; penable_a[2] = 1'b0; pwrite_a[2] = 1'b1;
            paddr_a[2] = 32'h14; pwdata_a[2] = 32'hFFFFFFFF; pstrb_a[2] = 4'hF;
            @(posedge clk); #1;
            penable_a[2] = 1'b1;
            @(negedge clk);
            seen = seen | pready_a[2];
            @(posedge clk); #1;
            bus_idle(2);
            repeat (6) begin
                @(negedge clk);
                seen = seen | pready_a[2];
            end
            check("abort no pready", 128'(seen), 128'h0);
            check("abort no write", regq_a[2], {32'h0, 32'h0, 32'h0, 32'h12345678});
        end

        // reset asserted while a write is waiting
        @(posedge clk); #1;
        psel_a[2] = 1'b1; penable_a[2] = 1'b0; pwrite_a[2] = 1'b1;
        paddr_a[2] = 32'h18; pwdata_a[2] = 32'h00000055; pstrb_a[2] = 4'hF;
        @(posedge clk); #1;
        penable_a[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre-reset pready", 128'(pready_a[2]), 128'h0);
        rst_a[2] = 1'b0;
        #1;
        check("mid reset reg_q", regq_a[2], 128'h0);
        check("mid reset pready", 128'(pready_a[2]), 128'h0);
        @(posedge clk); #1;
        bus_idle(2);
        @(posedge clk); #1;
        rst_a[2] = 1'b1;
        xfer("post reset write", 2, 1'b1, 32'h1C, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 5);
        xfer("post reset read", 2, 1'b0, 32'h1C, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 5);
        xfer("post reset reg2", 2, 1'b0, 32'h18, 32'h0, 4'h0, 32'h0, 1'b0, 5);
        check("post reset reg_q", regq_a[2], {32'hCAFEF00D, 32'h0, 32'h0, 32'h0});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
Name:
apb_regfile_slave

Overview:
- Parametrised APB4 slave register bank with NUM_REGS registers at BASE_ADDR + i*(DATA_WIDTH/8).
- Adds what the fixed 4-register slave lacks: programmable wait states, pstrb byte enables, per-register write masks, pslverr for unmapped or misaligned accesses, and a flat register export to core logic.
- Sits behind the APB interconnect as a control/status block.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8, range 8..64.
ADDR_WIDTH, 32, paddr width.
NUM_REGS, 4, number of registers; range 1..64.
BASE_ADDR, 'h10, byte address of register 0; aligned to DATA_WIDTH/8.
WAIT_CYCLES, 0, wait states inserted before pready; range 0..15.
WMASK, all ones, NUM_REGS*DATA_WIDTH bits; bit i*DATA_WIDTH+b set means reg i bit b is writable.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous active-low reset.
psel  in  1  slave select.
penable  in  1  access phase.
pwrite  in  1  1 = write, 0 = read.
paddr  in  ADDR_WIDTH  byte address.
pwdata  in  DATA_WIDTH  write data.
pstrb  in  DATA_WIDTH/8  byte write strobes.
prdata  out  DATA_WIDTH  read data; valid only when pready=1 and pwrite=0.
pready  out  1  transfer-complete.
pslverr  out  1  transfer error; qualified by pready.
reg_q  out  NUM_REGS*DATA_WIDTH  current register contents; reg i is at [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (rst=0, async): all registers 0, FSM to IDLE, wait counter 0. Outputs during reset: pready=0, pslverr=0, prdata=0, reg_q=0.
- Decode:
  - off = paddr - BASE_ADDR.
  - hit = (paddr >= BASE_ADDR) and (off mod (DATA_WIDTH/8) == 0) and (off/(DATA_WIDTH/8) < NUM_REGS).
  - idx = off/(DATA_WIDTH/8).
- FSM states IDLE, ACCESS.
  - IDLE: psel=1 and penable=0 (setup phase) -> ACCESS, wcnt<=0. Anything else stays in IDLE. penable=1 in IDLE is ignored (no pready, no write).
  - ACCESS with psel=1 and penable=1 and wcnt<WAIT_CYCLES: wcnt<=wcnt+1, pready=0.
  - ACCESS with psel=1 and penable=1 and wcnt==WAIT_CYCLES: pready=1 this cycle (combinational from state and counter), -> IDLE.
  - ACCESS with psel=0 (abort): -> IDLE, no write, no pready.
  - ACCESS with psel=1 and penable=0 (new setup): restart, wcnt<=0, stay ACCESS.
- Latency: WAIT_CYCLES=0 gives the standard 2-cycle transfer; each wait state adds one cycle. Back-to-back transfers need a setup cycle between them, so the minimum is 2 cycles per transfer.
- Write commit on the rising edge where pready=1, pwrite=1 and hit=1, for each bit b of reg[idx]:
  - The bit updates only if pstrb[b/8]=1 and WMASK bit is 1.
  - New value = pwdata[b]; otherwise the bit holds.
  - pstrb=0 is a legal no-op write with pslverr=0.
- Read: when pready=1, pwrite=0 and hit=1, prdata = reg[idx]. Otherwise prdata = 0. Reads have no side effects.
- Error: pslverr = pready and not hit.
  - A missed write changes no register.
  - A missed read returns prdata=0.
- reg_q reflects the committed value from the cycle after the commit edge.
- pready, pslverr and prdata are 0 whenever the FSM is not completing a transfer.
- Reset mid-transfer: immediate return to IDLE. A transfer without pready performs no write.

Test Plan:
- DATA_WIDTH=32, WAIT_CYCLES=0: write 0xDEADBEEF to 0x14 with pstrb=0xF, then read 0x14 -> pready high in the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0, reg_q[63:32]=0xDEADBEEF.
- WAIT_CYCLES=2: read 0x10 after reset -> pready low for 2 access cycles, high on the 3rd, prdata=0; total 4 cycles from setup.
- Write 0xAABBCCDD to 0x18 with pstrb=0x5 over prior value 0x11223344 -> reg reads 0x11BB33DD.
- WMASK reg1 = 0x0000000F: write 0xFFFFFFFF to 0x14 -> reads 0x0000000F.
- Access 0x20 (unmapped), 0x12 (misaligned) and 0x0C (below base) -> pslverr=1 with pready=1; no register changes; read returns 0.
- Abort and reset cases:
  - WAIT_CYCLES=3: drop psel in the 2nd access cycle of a write -> no write, no pready.
  - Assert rst mid-wait -> reg_q=0, pready=0.
  - A following normal transfer completes correctly.
